// File: rtl/tile_reset_pkg.sv
// Shared types and helpers for the tile reset sequencer.
package tile_reset_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FENCE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_ASSERT = 3'd3,
    ST_SETTLE = 3'd4
  } tile_state_e;

  // Width of a timer that counts 0 .. max_count-1.
  function automatic int unsigned tmr_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/tile_reset_sequencer_if.sv
// TileLink channel handshake observation plus the A-channel fence toward the tile wrapper.
interface tile_reset_sequencer_if;

  logic a_fire;
  logic a_last;
  logic c_rel_fire;
  logic d_fire;
  logic d_last;
  logic d_is_grant;
  logic e_fire;
  logic a_block;

  modport master (
    output a_fire, a_last, c_rel_fire, d_fire, d_last, d_is_grant, e_fire,
    input  a_block
  );

  modport slave (
    input  a_fire, a_last, c_rel_fire, d_fire, d_last, d_is_grant, e_fire,
    output a_block
  );

endinterface

// File: rtl/tile_reset_sequencer_tracker.sv
// Saturating outstanding-transaction and grant counters plus A-burst tracking.
module tile_txn_tracker
  import tile_reset_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             a_fire_i,
  input  logic             a_last_i,
  input  logic             c_rel_fire_i,
  input  logic             d_fire_i,
  input  logic             d_last_i,
  input  logic             d_is_grant_i,
  input  logic             e_fire_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             burst_next_o,
  output logic             quiescent_o
);

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] grants_q, grants_d;
  logic             in_burst_q, in_burst_d;
  logic [1:0]       out_inc;
  logic             out_dec;
  logic             gnt_inc;
  logic             gnt_dec;

  // Add up to two, subtract one, clamp to [0, all-ones].
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cur,
                                                input logic [1:0]       inc,
                                                input logic             dec);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, cur} + {{CNT_W{1'b0}}, inc};
    if (dec && (sum == '0)) return '0;
    sum = sum - {{(CNT_W+1){1'b0}}, dec};
    if (sum > {2'b00, {CNT_W{1'b1}}}) return '1;
    return sum[CNT_W-1:0];
  endfunction

  assign out_inc = {1'b0, a_fire_i & a_last_i} + {1'b0, c_rel_fire_i};
  assign out_dec = d_fire_i & d_last_i;
  assign gnt_inc = d_fire_i & d_last_i & d_is_grant_i;
  assign gnt_dec = e_fire_i;

  always_comb begin
    outstanding_d = sat_step(outstanding_q, out_inc, out_dec);
    grants_d      = sat_step(grants_q, {1'b0, gnt_inc}, gnt_dec);
    in_burst_d    = a_fire_i ? !a_last_i : in_burst_q;
    if (clear_i) begin
      outstanding_d = '0;
      grants_d      = '0;
      in_burst_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      grants_q      <= '0;
      in_burst_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      grants_q      <= grants_d;
      in_burst_q    <= in_burst_d;
    end
  end

  assign outstanding_o = outstanding_q;
  // The fence looks one beat ahead so a new message cannot start in the cycle the fence closes.
  assign burst_next_o  = in_burst_d;
  assign quiescent_o   = (outstanding_q == '0) && (grants_q == '0) && !in_burst_q;

endmodule

// File: rtl/tile_reset_sequencer.sv
// Fences, drains, resets and settles one tile reset domain on power-on or software request.
// Optional drain timeout is enabled by defining TILE_RST_DRAIN_TIMEOUT_EN.
module tile_reset_sequencer
  import tile_reset_pkg::*;
#(
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sw_reset_req,
  tile_reset_sequencer_if.slave tl,
  output logic                  tile_reset,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  drain_timeout
);

  localparam logic [2:0] S_RUN    = ST_RUN;
  localparam logic [2:0] S_FENCE  = ST_FENCE;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;
  localparam logic [2:0] S_ASSERT = ST_ASSERT;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;

  localparam int unsigned TMR_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = tmr_width(TMR_MAX);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tile_reset_q, tile_reset_d;
  logic             a_block_q, a_block_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             burst_next;
  logic             quiescent;

  tile_txn_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_i       (tile_reset_q),
    .a_fire_i      (tl.a_fire),
    .a_last_i      (tl.a_last),
    .c_rel_fire_i  (tl.c_rel_fire),
    .d_fire_i      (tl.d_fire),
    .d_last_i      (tl.d_last),
    .d_is_grant_i  (tl.d_is_grant),
    .e_fire_i      (tl.e_fire),
    .outstanding_o (outstanding),
    .burst_next_o  (burst_next),
    .quiescent_o   (quiescent)
  );

`ifdef TILE_RST_DRAIN_TIMEOUT_EN
  localparam int unsigned DRN_W = tmr_width(TIMEOUT_CYCLES);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(TIMEOUT_CYCLES - 1);

  logic [DRN_W-1:0] drn_tmr_q, drn_tmr_d;
  logic             drain_timeout_q;
  logic             tmo_hit;

  // Drained counters win over a timeout that lands in the same cycle.
  assign tmo_hit   = (state_q == S_DRAIN) && !quiescent && (drn_tmr_q == DRN_LAST);
  assign drn_tmr_d = ((state_q == S_DRAIN) && (state_d == S_DRAIN)) ? drn_tmr_q + 1'b1 : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drn_tmr_q       <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      drn_tmr_q       <= drn_tmr_d;
      drain_timeout_q <= drain_timeout_q | tmo_hit;
    end
  end

  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (sw_reset_req) state_d = S_FENCE;
      S_FENCE:  if (!burst_next) state_d = S_DRAIN;
      S_DRAIN: begin
        if (quiescent) state_d = S_ASSERT;
`ifdef TILE_RST_DRAIN_TIMEOUT_EN
        else if (tmo_hit) state_d = S_ASSERT;
`endif
      end
      S_ASSERT: if (tmr_q == RST_LAST) state_d = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
      S_SETTLE: if (tmr_q == SET_LAST) state_d = S_RUN;
      default:  state_d = S_ASSERT;
    endcase
  end

  always_comb begin
    tmr_d = '0;
    if ((state_d == state_q) && ((state_q == S_ASSERT) || (state_q == S_SETTLE)))
      tmr_d = tmr_q + 1'b1;
  end

  // Outputs are decoded from the next state so they change together with it.
  always_comb begin
    tile_reset_d = (state_d == S_ASSERT);
    a_block_d    = !((state_d == S_RUN) || (state_d == S_FENCE));
    busy_d       = (state_d != S_RUN);
    done_d       = (state_d == S_RUN) && (state_q != S_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_ASSERT;
      tmr_q        <= '0;
      tile_reset_q <= 1'b1;
      a_block_q    <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      tile_reset_q <= tile_reset_d;
      a_block_q    <= a_block_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tile_reset = tile_reset_q;
  assign tl.a_block = a_block_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Self-checking bench for tile_reset_sequencer: directed sequencing scenarios plus randomized counter traffic.
module tb_tile_reset_sequencer;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned RST_C = 16;
  localparam int unsigned SET_C = 8;
  localparam int unsigned TMO_C = 32;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic             sw_reset_req;
  logic             tile_reset;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] outstanding;
  logic             drain_timeout;

  int total = 0;
  int bad   = 0;

  tile_reset_sequencer_if tl ();

  tile_reset_sequencer #(
    .CNT_W         (CNT_W),
    .RESET_CYCLES  (RST_C),
    .SETTLE_CYCLES (SET_C),
    .TIMEOUT_CYCLES(TMO_C)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sw_reset_req (sw_reset_req),
    .tl           (tl),
    .tile_reset   (tile_reset),
    .busy         (busy),
    .done         (done),
    .outstanding  (outstanding),
    .drain_timeout(drain_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    tl.a_fire     = 1'b0;
    tl.a_last     = 1'b0;
    tl.c_rel_fire = 1'b0;
    tl.d_fire     = 1'b0;
    tl.d_last     = 1'b0;
    tl.d_is_grant = 1'b0;
    tl.e_fire     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    reset_n      = 1'b0;
    sw_reset_req = 1'b0;
    idle_bus();
    repeat (3) tick();
    total++;
    if ({tile_reset, tl.a_block, busy, done, drain_timeout} !== 5'b11100) begin
      bad++;
      $display("FAIL reset_outputs got tr/ab/busy/done/tmo=%b want=11100",
               {tile_reset, tl.a_block, busy, done, drain_timeout});
    end
    total++;
    if (outstanding !== '0) begin
      bad++;
      $display("FAIL reset_outstanding got=%0d want=0", outstanding);
    end
    reset_n = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      exp_v = {k < RST_C, k < RST_C + SET_C, k < RST_C + SET_C, k == RST_C + SET_C};
      total++;
      if ({tile_reset, tl.a_block, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL power_on k=%0d got tr/ab/busy/done=%b want=%b",
                 k, {tile_reset, tl.a_block, busy, done}, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_counters();
    int  o;
    int  pinc;
    int  nxt;
    bit  a, al, c, dd, dl;
    o = 0;
    for (int i = 0; i < 350; i++) begin
      pinc = (i < 100) ? 80 : 10;
      a  = ($urandom_range(99) < pinc);
      al = $urandom_range(1);
      c  = ($urandom_range(99) < pinc);
      dd = ($urandom_range(99) < (100 - pinc));
      dl = $urandom_range(1);
      tl.a_fire = a; tl.a_last = al; tl.c_rel_fire = c;
      tl.d_fire = dd; tl.d_last = dl;
      tick();
      nxt = o + int'(a & al) + int'(c) - int'(dd & dl);
      if (nxt < 0) nxt = 0;
      if (nxt > CMAX) nxt = CMAX;
      o = nxt;
      total++;
      if (outstanding !== CNT_W'(o)) begin
        bad++;
        $display("FAIL rand_outstanding i=%0d got=%0d want=%0d", i, outstanding, o);
      end
    end
    idle_bus();
    tl.d_fire = 1'b1; tl.d_last = 1'b1;
    repeat (CMAX + 2) tick();
    idle_bus();
    total++;
    if (outstanding !== '0) begin
      bad++;
      $display("FAIL underflow_hold got=%0d want=0", outstanding);
    end
    tl.a_fire = 1'b1; tl.a_last = 1'b1;
    repeat (3) tick();
    idle_bus();
    total++;
    if (outstanding !== CNT_W'(3)) begin
      bad++;
      $display("FAIL three_acquires got=%0d want=3", outstanding);
    end
    tl.a_fire = 1'b1; tl.a_last = 1'b1; tl.c_rel_fire = 1'b1;
    tl.d_fire = 1'b1; tl.d_last = 1'b1;
    tick();
    idle_bus();
    total++;
    if (outstanding !== CNT_W'(4)) begin
      bad++;
      $display("FAIL simultaneous_a_c_d got=%0d want=4", outstanding);
    end
    tl.d_fire = 1'b1; tl.d_last = 1'b1;
    repeat (5) tick();
    idle_bus();
    total++;
    if (outstanding !== '0) begin
      bad++;
      $display("FAIL decrement_at_zero got=%0d want=0", outstanding);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL run_stays_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_idle_req();
    logic [4:0] exp_v;
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      exp_v = {(k >= 2) && (k < 18), (k >= 1) && (k < 26), k < 26, k == 26, 1'b0};
      total++;
      if ({tile_reset, tl.a_block, busy, done, outstanding != '0} !== exp_v) begin
        bad++;
        $display("FAIL idle_req k=%0d got tr/ab/busy/done/outnz=%b want=%b",
                 k, {tile_reset, tl.a_block, busy, done, outstanding != '0}, exp_v);
      end
      sw_reset_req = (k == 10);
      tick();
    end
    sw_reset_req = 1'b0;
  endtask

  task automatic test_burst_fence();
    bit ok;
    bit held;
    tl.a_fire = 1'b1; tl.a_last = 1'b0;
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    total++;
    if ({tl.a_block, busy} !== 2'b01) begin
      bad++;
      $display("FAIL fence_beat2 got ab/busy=%b want=01", {tl.a_block, busy});
    end
    tick();
    total++;
    if (tl.a_block !== 1'b0) begin
      bad++;
      $display("FAIL fence_beat3 a_block got=%b want=0", tl.a_block);
    end
    tl.a_last = 1'b1;
    tick();
    idle_bus();
    for (int i = 0; i < 2 && tl.a_block !== 1'b1; i++) tick();
    total++;
    if (tl.a_block !== 1'b1) begin
      bad++;
      $display("FAIL fence_release a_block got=%b want=1", tl.a_block);
    end
    total++;
    if (outstanding !== CNT_W'(1)) begin
      bad++;
      $display("FAIL fence_outstanding got=%0d want=1", outstanding);
    end
    held = 1'b1;
    repeat (6) begin
      tick();
      if (tile_reset !== 1'b0 || tl.a_block !== 1'b1) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL drain_waits_for_d got tr=%b want=0", tile_reset);
    end
    tl.d_fire = 1'b1; tl.d_last = 1'b1;
    tick();
    idle_bus();
    for (int i = 0; i < 3 && tile_reset !== 1'b1; i++) tick();
    total++;
    if (tile_reset !== 1'b1) begin
      bad++;
      $display("FAIL assert_after_d got tr=%b want=1", tile_reset);
    end
    wait_done(40, ok);
    total++;
    if (!ok || outstanding !== '0) begin
      bad++;
      $display("FAIL burst_done got done_seen=%0d outstanding=%0d want 1,0", ok, outstanding);
    end
  endtask

  task automatic test_grant_drain();
    bit ok;
    bit held;
    tl.a_fire = 1'b1; tl.a_last = 1'b1;
    tick();
    idle_bus();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    tick();
    tl.d_fire = 1'b1; tl.d_is_grant = 1'b1; tl.d_last = 1'b0;
    tick();
    tl.d_last = 1'b1;
    tick();
    idle_bus();
    total++;
    if (outstanding !== '0) begin
      bad++;
      $display("FAIL grant_outstanding got=%0d want=0", outstanding);
    end
    held = 1'b1;
    repeat (5) begin
      tick();
      if (tile_reset !== 1'b0 || tl.a_block !== 1'b1 || busy !== 1'b1) held = 1'b0;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL grant_holds_drain got tr/ab/busy=%b want=011", {tile_reset, tl.a_block, busy});
    end
    tl.e_fire = 1'b1;
    tick();
    idle_bus();
    for (int i = 0; i < 2 && tile_reset !== 1'b1; i++) tick();
    total++;
    if (tile_reset !== 1'b1) begin
      bad++;
      $display("FAIL assert_after_e got tr=%b want=1", tile_reset);
    end
    wait_done(40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL grant_done got done_seen=0 want=1");
    end
  endtask

  task automatic test_drain_stuck();
    bit ok;
    int n;
    tl.a_fire = 1'b1; tl.a_last = 1'b1;
    tick();
    idle_bus();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
`ifdef TILE_RST_DRAIN_TIMEOUT_EN
    n = 0;
    while (tile_reset !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n != 1 + TMO_C || drain_timeout !== 1'b1) begin
      bad++;
      $display("FAIL drain_timeout got cycles=%0d flag=%b want=%0d,1", n, drain_timeout, 1 + TMO_C);
    end
    wait_done(40, ok);
    total++;
    if (!ok || drain_timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky got done_seen=%0d flag=%b want 1,1", ok, drain_timeout);
    end
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    repeat (3) tick();
`else
    ok = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (tile_reset !== 1'b0 || tl.a_block !== 1'b1 || busy !== 1'b1 ||
          drain_timeout !== 1'b0 || outstanding !== CNT_W'(1)) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_forever got tr/ab/busy/tmo=%b out=%0d want=0110 out=1",
               {tile_reset, tl.a_block, busy, drain_timeout}, outstanding);
    end
`endif
    reset_n = 1'b0;
    #1;
    total++;
    if ({tile_reset, tl.a_block, busy, done, drain_timeout} !== 5'b11100 || outstanding !== '0) begin
      bad++;
      $display("FAIL midseq_reset got tr/ab/busy/done/tmo=%b out=%0d want=11100 out=0",
               {tile_reset, tl.a_block, busy, done, drain_timeout}, outstanding);
    end
    tick();
    tick();
    reset_n = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n != RST_C + SET_C) begin
      bad++;
      $display("FAIL restart_done got cycles=%0d want=%0d", n, RST_C + SET_C);
    end
  endtask

  initial begin
    test_reset();
    test_counters();
    test_idle_req();
    test_burst_fence();
    test_grant_drain();
    test_drain_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
